// File: rtl/decoder_pkg.sv
// Shared decode types for the instruction decode queue: RV32I opcodes, the
// instruction format enum and the decoded entry held in each FIFO slot.
package decoder_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Widest PC the entry can carry; the top keeps only its low XLEN bits.
  localparam int PC_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [PC_MAX-1:0] pc;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    fmt_e              fmt;
    logic              illegal;
  } decoded_instr_t;

  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_OP:                                           return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:   return FMT_I;
      OP_STORE:                                        return FMT_S;
      OP_BRANCH:                                       return FMT_B;
      OP_LUI, OP_AUIPC:                                return FMT_U;
      OP_JAL:                                          return FMT_J;
      default:                                         return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate bits of an instruction word according to its decoded format.
module imm_gen
  import decoder_pkg::*;
(
  input  logic [31:0] instr_i,
  input  fmt_e        fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = 32'd0;
    case (fmt_i)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'd0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Decode stage: decodes RV32I words at the input and buffers them in a
// DEPTH-entry FIFO for issue. Optional macro RV32E_REGS_EN adds a 16-register check.
module instruction_decode_queue
  import decoder_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [XLEN-1:0]            in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [6:0]                 opcode_o,
  output logic [4:0]                 rd_o,
  output logic [2:0]                 funct3_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [6:0]                 funct7_o,
  output logic [31:0]                imm_o,
  output logic [2:0]                 fmt_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready_o is a function of the registered count only, and
  // out_valid_o never depends on in_valid_i (no bypass).

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  decoded_instr_t mem [DEPTH];
  decoded_instr_t new_entry, head;
  fmt_e           dec_fmt;
  logic [31:0]    dec_imm;
  logic           dec_illegal;
  logic           push, pop;

  assign dec_fmt = decode_fmt(in_instr_i[6:0]);

  imm_gen u_imm_gen (
    .instr_i (in_instr_i),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

  always_comb begin
    dec_illegal = 1'b0;
    if (in_instr_i[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_fmt == FMT_NONE)      dec_illegal = 1'b1;
    if (dec_fmt == FMT_R) begin
      if (in_instr_i[31:25] != 7'b0000000 && in_instr_i[31:25] != 7'b0100000)
        dec_illegal = 1'b1;
      if (in_instr_i[31:25] == 7'b0100000 &&
          in_instr_i[14:12] != 3'b000 && in_instr_i[14:12] != 3'b101)
        dec_illegal = 1'b1;
    end
    if (dec_fmt == FMT_B && in_instr_i[14:13] == 2'b01) dec_illegal = 1'b1;
`ifdef RV32E_REGS_EN
    // Only the register fields a format actually uses are range-checked.
    if (in_instr_i[11] && (dec_fmt == FMT_R || dec_fmt == FMT_I ||
                           dec_fmt == FMT_U || dec_fmt == FMT_J))
      dec_illegal = 1'b1;
    if (in_instr_i[19] && (dec_fmt == FMT_R || dec_fmt == FMT_I ||
                           dec_fmt == FMT_S || dec_fmt == FMT_B))
      dec_illegal = 1'b1;
    if (in_instr_i[24] && (dec_fmt == FMT_R || dec_fmt == FMT_S ||
                           dec_fmt == FMT_B))
      dec_illegal = 1'b1;
`endif
  end

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = PC_MAX'(in_pc_i);
    new_entry.opcode  = in_instr_i[6:0];
    new_entry.rd      = in_instr_i[11:7];
    new_entry.funct3  = in_instr_i[14:12];
    new_entry.rs1     = in_instr_i[19:15];
    new_entry.rs2     = in_instr_i[24:20];
    new_entry.funct7  = in_instr_i[31:25];
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
  end

  assign in_ready_o  = (count < CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= new_entry;
  end

  always_comb begin
    head = '0;
    if (out_valid_o) head = mem[rd_ptr];
  end

  assign out_pc_o  = head.pc[XLEN-1:0];
  assign opcode_o  = head.opcode;
  assign rd_o      = head.rd;
  assign funct3_o  = head.funct3;
  assign rs1_o     = head.rs1;
  assign rs2_o     = head.rs2;
  assign funct7_o  = head.funct7;
  assign imm_o     = head.imm;
  assign fmt_o     = head.fmt;
  assign illegal_o = head.illegal;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Self-checking bench for instruction_decode_queue: directed cases plus
// randomized traffic checked against a queue-based reference model.
module tb_instruction_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [31:0]     in_instr_i = '0;
  logic [XLEN-1:0] in_pc_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [XLEN-1:0] out_pc_o;
  logic [6:0]      opcode_o;
  logic [4:0]      rd_o;
  logic [2:0]      funct3_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [6:0]      funct7_o;
  logic [31:0]     imm_o;
  logic [2:0]      fmt_o;
  logic            illegal_o;
  logic [CW-1:0]   count_o;

  instruction_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct7_o(funct7_o), .imm_o(imm_o), .fmt_o(fmt_o),
    .illegal_o(illegal_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  // Each model entry is {pc, instr}, oldest at index 0.
  logic [XLEN+31:0] exp_q[$];

  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                      7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode derived directly from the RV32I format tables.
  function automatic void ref_decode(input logic [31:0] w, output logic [2:0] fmt,
                                     output logic [31:0] imm, output logic ill);
    logic [6:0] op;
    logic use_rd, use_rs1, use_rs2;
    op = w[6:0];
    if (op == 7'h33) fmt = 3'd0;
    else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F) fmt = 3'd1;
    else if (op == 7'h23) fmt = 3'd2;
    else if (op == 7'h63) fmt = 3'd3;
    else if (op == 7'h37 || op == 7'h17) fmt = 3'd4;
    else if (op == 7'h6F) fmt = 3'd5;
    else fmt = 3'd6;
    case (fmt)
      3'd1: imm = 32'($signed(w[31:20]));
      3'd2: imm = 32'($signed({w[31:25], w[11:7]}));
      3'd3: imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd4: imm = {w[31:12], 12'h000};
      3'd5: imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: imm = 32'h0;
    endcase
    ill = (w[1:0] != 2'b11) || (fmt == 3'd6);
    if (fmt == 3'd0 && !(w[31:25] == 7'h00 || w[31:25] == 7'h20)) ill = 1'b1;
    if (fmt == 3'd0 && w[31:25] == 7'h20 && !(w[14:12] == 3'd0 || w[14:12] == 3'd5)) ill = 1'b1;
    if (fmt == 3'd3 && (w[14:12] == 3'd2 || w[14:12] == 3'd3)) ill = 1'b1;
    use_rd  = (fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd4 || fmt == 3'd5);
    use_rs1 = (fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd2 || fmt == 3'd3);
    use_rs2 = (fmt == 3'd0 || fmt == 3'd2 || fmt == 3'd3);
`ifdef RV32E_REGS_EN
    if ((use_rd && w[11]) || (use_rs1 && w[19]) || (use_rs2 && w[24])) ill = 1'b1;
`else
    if (use_rd && use_rs1 && use_rs2 && 1'b0) ill = 1'b1;
`endif
  endfunction

  task automatic check_outputs();
    logic [31:0] w, e_imm;
    logic [XLEN-1:0] e_pc;
    logic [2:0] e_fmt;
    logic e_ill;
    int n;
    n = exp_q.size();
    check_eq("count", 32'(count_o), 32'(n));
    check_eq("in_ready", 32'(in_ready_o), 32'(n < DEPTH));
    check_eq("out_valid", 32'(out_valid_o), 32'(n > 0));
    if (n > 0) begin
      w = exp_q[0][31:0];
      e_pc = exp_q[0][XLEN+31:32];
      ref_decode(w, e_fmt, e_imm, e_ill);
    end else begin
      w = 32'h0; e_pc = '0; e_fmt = 3'd0; e_imm = 32'h0; e_ill = 1'b0;
    end
    check_eq("pc", 32'(out_pc_o), 32'(e_pc));
    check_eq("opcode", 32'(opcode_o), 32'(w[6:0]));
    check_eq("rd", 32'(rd_o), 32'(w[11:7]));
    check_eq("funct3", 32'(funct3_o), 32'(w[14:12]));
    check_eq("rs1", 32'(rs1_o), 32'(w[19:15]));
    check_eq("rs2", 32'(rs2_o), 32'(w[24:20]));
    check_eq("funct7", 32'(funct7_o), 32'(w[31:25]));
    check_eq("imm", imm_o, e_imm);
    check_eq("fmt", 32'(fmt_o), 32'(e_fmt));
    check_eq("illegal", 32'(illegal_o), 32'(e_ill));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, update model, check.
  task automatic step(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc,
                      input logic rdy, input logic fl);
    logic do_push, do_pop;
    in_valid_i = v; in_instr_i = instr; in_pc_i = pc;
    out_ready_i = rdy; flush_i = fl;
    do_push = v && (exp_q.size() < DEPTH);
    do_pop  = rdy && (exp_q.size() > 0);
    @(posedge clk_i);
    if (fl) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, instr});
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) w[6:0] = OPS[k];
    if (k == 0 && $urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    #1;
    check_eq("rst_count", 32'(count_o), 32'd0);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_ready", 32'(in_ready_o), 32'd1);
    check_eq("rst_imm", imm_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    check_eq("addi_valid", 32'(out_valid_o), 32'd1);
    check_eq("addi_pc", out_pc_o, 32'h100);
    check_eq("addi_opcode", 32'(opcode_o), 32'h13);
    check_eq("addi_rd", 32'(rd_o), 32'd1);
    check_eq("addi_rs1", 32'(rs1_o), 32'd0);
    check_eq("addi_fmt", 32'(fmt_o), 32'd1);
    check_eq("addi_imm", imm_o, 32'h5);
    check_eq("addi_illegal", 32'(illegal_o), 32'd0);

    step(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0);
    check_eq("sw_fmt", 32'(fmt_o), 32'd2);
    check_eq("sw_rs1", 32'(rs1_o), 32'd2);
    check_eq("sw_rs2", 32'(rs2_o), 32'd1);
    check_eq("sw_funct3", 32'(funct3_o), 32'd2);
    check_eq("sw_imm", imm_o, 32'hFFFFFFFC);

    step(1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0);
    check_eq("lui_fmt", 32'(fmt_o), 32'd4);
    check_eq("lui_rd", 32'(rd_o), 32'd5);
    check_eq("lui_imm", imm_o, 32'h12345000);

    step(1'b1, 32'h00000000, 32'h10C, 1'b1, 1'b0);
    check_eq("zero_illegal", 32'(illegal_o), 32'd1);
    check_eq("zero_fmt", 32'(fmt_o), 32'd6);
    check_eq("zero_imm", imm_o, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_eq("drained_valid", 32'(out_valid_o), 32'd0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_instr(), 32'(32'h200 + 4 * i), 1'b0, 1'b0);
    check_eq("full_count", 32'(count_o), 32'(DEPTH));
    check_eq("full_ready", 32'(in_ready_o), 32'd0);
    step(1'b1, 32'h00100113, 32'h2F0, 1'b0, 1'b0);
    check_eq("full_ignore", 32'(count_o), 32'(DEPTH));
    step(1'b1, 32'h00100113, 32'h2F4, 1'b1, 1'b0);
    check_eq("full_pop_count", 32'(count_o), 32'(DEPTH - 1));
    check_eq("full_pop_ready", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, rand_instr(), 32'(32'h300 + 4 * i), 1'b1, 1'b0);

    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, rand_instr(), 32'h400, 1'b0, 1'b0);
    step(1'b1, rand_instr(), 32'h404, 1'b0, 1'b0);
    step(1'b1, rand_instr(), 32'h408, 1'b1, 1'b1);
    check_eq("flush_count", 32'(count_o), 32'd0);
    check_eq("flush_valid", 32'(out_valid_o), 32'd0);
    check_eq("flush_ready", 32'(in_ready_o), 32'd1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), 32'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

    step(1'b1, rand_instr(), 32'h500, 1'b0, 1'b0);
    step(1'b1, rand_instr(), 32'h504, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_count", 32'(count_o), 32'd0);
    check_eq("arst_valid", 32'(out_valid_o), 32'd0);
    check_eq("arst_ready", 32'(in_ready_o), 32'd1);
    check_eq("arst_pc", out_pc_o, 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 50; i++)
      step($urandom_range(0, 1) == 1, rand_instr(), 32'($urandom),
           $urandom_range(0, 1) == 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
